// File: rtl/imem_port_arbiter.sv
// Single-port instruction memory arbiter between the IF fetch port and the
// debug/program-loader port; one access per cycle, registered 1-cycle response.
//
// last_gnt   | meaning
// OWN_FETCH  | most recent grant went to fetch (next tie favours debug)
// OWN_DEBUG  | most recent grant went to debug, or reset (next tie favours fetch)
module imem_port_arbiter #(
   parameter int DEPTH      = 1024,
   parameter int AW         = 10,
   parameter int LOCK_LIMIT = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          f_req,
   input  logic [31:0]   f_addr,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic [31:0]   f_rdata,
   output logic          f_err,
   input  logic          d_req,
   input  logic          d_we,
   input  logic          d_lock,
   input  logic [31:0]   d_addr,
   input  logic [31:0]   d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [31:0]   d_rdata,
   output logic          d_err,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [31:0]   mem_wdata,
   input  logic [31:0]   mem_rdata
);

   typedef enum logic {OWN_FETCH, OWN_DEBUG} owner_t;

   owner_t        last_gnt, last_gnt_nxt;
   logic          primed, primed_nxt;
   logic [7:0]    lock_cnt, lock_cnt_nxt;
   logic [AW-1:0] addr_q, addr_nxt;
   logic [31:0]   gaddr;
   logic          legal;
   logic          any_gnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gnt <= OWN_DEBUG;
         primed   <= 1'b0;
         lock_cnt <= '0;
         addr_q   <= '0;
         f_rvalid <= 1'b0;
         f_rdata  <= '0;
         f_err    <= 1'b0;
         d_rvalid <= 1'b0;
         d_rdata  <= '0;
         d_err    <= 1'b0;
      end else begin
         last_gnt <= last_gnt_nxt;
         primed   <= primed_nxt;
         lock_cnt <= lock_cnt_nxt;
         addr_q   <= addr_nxt;
         f_rvalid <= f_gnt;
         f_rdata  <= (f_gnt && legal) ? mem_rdata : '0;
         f_err    <= f_gnt && !legal;
         d_rvalid <= d_gnt;
         d_rdata  <= (d_gnt && legal && !d_we) ? mem_rdata : '0;
         d_err    <= d_gnt && !legal;
      end
   end

   always_comb begin
      f_gnt        = 1'b0;
      d_gnt        = 1'b0;
      last_gnt_nxt = last_gnt;
      primed_nxt   = primed;
      lock_cnt_nxt = lock_cnt;
      addr_nxt     = addr_q;

      // Burst continuation needs a real debug grant since reset; the reset
      // value of last_gnt alone must not let a locked burst beat fetch.
      if (!rst) begin
         if (f_req && !d_req) begin
            f_gnt = 1'b1;
         end else if (d_req && !f_req) begin
            d_gnt = 1'b1;
         end else if (f_req && d_req) begin
            if (lock_cnt == 8'(LOCK_LIMIT))
               f_gnt = 1'b1;
            else if (d_lock && primed && last_gnt == OWN_DEBUG)
               d_gnt = 1'b1;
            else if (last_gnt == OWN_DEBUG)
               f_gnt = 1'b1;
            else
               d_gnt = 1'b1;
         end
      end

      any_gnt = f_gnt || d_gnt;
      gaddr   = d_gnt ? d_addr : f_addr;
      legal   = (gaddr[1:0] == 2'b00) && (gaddr[31:2] < 30'(DEPTH));

      if (any_gnt && legal) begin
         mem_addr  = gaddr[AW+1:2];
         mem_wdata = d_wdata;
         addr_nxt  = gaddr[AW+1:2];
      end else begin
         mem_addr  = addr_q;
         mem_wdata = '0;
      end
      mem_we = d_gnt && legal && d_we;

      if (f_gnt) begin
         last_gnt_nxt = OWN_FETCH;
         primed_nxt   = 1'b1;
      end else if (d_gnt) begin
         last_gnt_nxt = OWN_DEBUG;
         primed_nxt   = 1'b1;
      end

      if (!f_req || f_gnt)
         lock_cnt_nxt = '0;
      else if (d_gnt && lock_cnt != 8'(LOCK_LIMIT))
         lock_cnt_nxt = lock_cnt + 8'd1;
   end

endmodule
